mux_scan_ctrl: RTL

- Upstream sequencer for the team's 8:1 mux (always_8_1mux: in[7:0], s[2:0], y).
- On a start request it latches an 8-bit word and drives it onto the mux data bus. It then steps the select 0..7, one per clock.
- It samples the mux output y back each cycle, producing an LSB-first serial stream, a reconstructed capture word and a sticky mismatch flag.
- Acts as a parallel-to-serial front end plus built-in self-check of the mux.

---
 rtl/mux_scan_ctrl_if.sv | 35 +++
 rtl/mux_scan_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if
//   Bundles the sequencer's request/data/mux/status signals.
//   master : the requesting side plus the external 8:1 mux (drives start,
//            data_in, mux_y; observes everything else).
//   slave  : the mux_scan_ctrl sequencer itself.
//   Signals:
//     start, data_in[7:0]  scan request and the word to serialize
//     mux_y                output y of the external 8:1 mux
//     mux_in[7:0], sel[2:0] registered data bus and select toward the mux
//     busy, done           activity flag and one-cycle completion pulse
//     ser_out, ser_valid   LSB-first serial stream and its qualifier
//     cap_word[7:0], err   word rebuilt from mux_y and sticky mismatch flag
interface mux_scan_ctrl_if;
   logic       start;
   logic [7:0] data_in;
   logic       mux_y;
   logic [7:0] mux_in;
   logic [2:0] sel;
   logic       busy;
   logic       ser_out;
   logic       ser_valid;
   logic [7:0] cap_word;
   logic       done;
   logic       err;

   modport master (
      output start, data_in, mux_y,
      input  mux_in, sel, busy, ser_out, ser_valid, cap_word, done, err
   );

   modport slave (
      input  start, data_in, mux_y,
      output mux_in, sel, busy, ser_out, ser_valid, cap_word, done, err
   );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Upstream sequencer for the 8:1 mux (always_8_1mux). On an accepted start
//   it latches data_in onto the mux data bus, steps the select 0..7 one per
//   clock, samples mux_y back each cycle and emits it as an LSB-first serial
//   stream, rebuilds the word in cap_word and sets a sticky err on any
//   disagreement between mux_y and the bit that should have been selected.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    mux_scan_ctrl_if.slave (start, data_in, mux_y in; mux_in, sel,
//            busy, ser_out, ser_valid, cap_word, done, err out)
//   Parameters: N_CH (=8) mux channels, SEL_W (=log2(N_CH)) select width.
//   Optional build macro MUX_SCAN_PARITY_EN: appends one PARITY cycle after
//   the scan that emits even parity of cap_word on ser_out, delaying done.
module mux_scan_ctrl #(
   parameter int N_CH  = 8,
   parameter int SEL_W = 3
) (
   input logic            clk,
   input logic            reset,
   mux_scan_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_PARITY,
      S_DONE
   } state_t;

   state_t state, state_nxt;
   logic   last_sel;
   logic   busy_c;
   logic   done_c;

   assign last_sel = (bus.sel == SEL_W'(N_CH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy_c    = 1'b1;
      done_c    = 1'b0;
      case (state)
         S_IDLE: begin
            busy_c = 1'b0;
            if (bus.start) state_nxt = S_SCAN;
         end
         S_SCAN: begin
            if (last_sel) begin
`ifdef MUX_SCAN_PARITY_EN
               state_nxt = S_PARITY;
`else
               state_nxt = S_DONE;
`endif
            end
         end
         S_PARITY: state_nxt = S_DONE;
         S_DONE: begin
            done_c    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.busy = busy_c;
   assign bus.done = done_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.mux_in    <= '0;
         bus.sel       <= '0;
         bus.ser_out   <= 1'b0;
         bus.ser_valid <= 1'b0;
         bus.cap_word  <= '0;
         bus.err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               bus.ser_valid <= 1'b0;
               if (bus.start) begin
                  bus.mux_in   <= bus.data_in;
                  bus.sel      <= '0;
                  bus.cap_word <= '0;
                  bus.err      <= 1'b0;
               end
            end
            S_SCAN: begin
               bus.ser_out           <= bus.mux_y;
               bus.ser_valid         <= 1'b1;
               bus.cap_word[bus.sel] <= bus.mux_y;
               // Case inequality so an X/Z on mux_y also flags a mismatch.
               if (bus.mux_y !== bus.mux_in[bus.sel]) bus.err <= 1'b1;
               // sel parks on the last channel rather than wrapping.
               if (!last_sel) bus.sel <= bus.sel + SEL_W'(1);
            end
            S_PARITY: begin
               bus.ser_out   <= ^bus.cap_word;
               bus.ser_valid <= 1'b1;
            end
            S_DONE: begin
               bus.ser_valid <= 1'b0;
            end
            default: begin
               bus.ser_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
